posit_acc: RTL and testbench

Streaming posit accumulator that sums a packet of N-bit posits (es exponent bits) arriving over a valid/ready stream and returns one rounded posit sum per packet. It sits downstream of the operand source and wraps one combinational `posit_add` instance. That instance's second operand is the input stream and its first operand is the running-sum register. The block adds packet framing, a sticky NaR flag, an element counter and output back-pressure.

---
 rtl/posit_pkg.sv | 18 +
 rtl/posit_add.sv | 120 ++++++++++++
 rtl/posit_acc.sv | 93 +++++++++
 tb/tb_posit_acc.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared types, posit constants and counter helper for the posit accumulator
package posit_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Constants are kept at the widest supported posit and sliced from the top by users.
    localparam int          POSIT_MAX_W    = 64;
    localparam logic [63:0] POSIT_NAR_MAX  = {1'b1, 63'b0};
    localparam logic [63:0] POSIT_ZERO_MAX = 64'b0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/posit_add.sv
// rtl/posit_add.sv - combinational posit adder, round-to-nearest-even on the encoding
module posit_add #(
    parameter int N  = 16,
    parameter int es = 2
) (
    input  logic         start,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N-1:0] out,
    output logic         inf,
    output logic         zero,
    output logic         done
);
    localparam int MW = N - es;
    localparam int EW = 2 * MW + 2;
    localparam int SW = $clog2(N) + es + 3;
    localparam int TW = EW + es + 1;
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-2:0] MAXPOS = '1;
    localparam logic [N-2:0] MINPOS = (N-1)'(1);

    function automatic void decode(input  logic [N-1:0]          x,
                                   output logic                  s,
                                   output logic signed [SW-1:0]  sf,
                                   output logic [MW-1:0]         m);
        logic [N-2:0]         body;
        logic [N-2:0]         rem;
        logic                 rb;
        int                   run;
        logic signed [SW-1:0] k;
        s    = x[N-1];
        body = (N-1)'(s ? -x : x);
        rb   = body[N-2];
        run  = 0;
        for (int i = N - 2; i >= 0; i--)
            if (body[i] == rb && run == N - 2 - i) run++;
        rem = body << (run + 1);
        k   = rb ? SW'(run - 1) : -SW'(run);
        sf  = (k <<< es) + SW'(rem[N-2 -: es]);
        m   = {1'b1, rem[N-2-es:0]};
    endfunction

    logic                 sa, sb, a_big, s_big, s_sml, sticky, lost, guard, rest, up;
    logic signed [SW-1:0] fa, fb, f_big, f_sml, diff, sf_r, k_r;
    logic [MW-1:0]        ma, mb, m_big, m_sml;
    logic [EW-1:0]        big_x, sml_x, sml_sh, sum;
    logic [EW-2:0]        frac;
    logic [TW-1:0]        seed, shifted;
    logic [N-2:0]         body_r, mag;
    int                   lead, shamt;

    always_comb begin
        decode(in1, sa, fa, ma);
        decode(in2, sb, fb, mb);
        a_big = (fa > fb) || (fa == fb && ma >= mb);
        s_big = a_big ? sa : sb;
        s_sml = a_big ? sb : sa;
        f_big = a_big ? fa : fb;
        f_sml = a_big ? fb : fa;
        m_big = a_big ? ma : mb;
        m_sml = a_big ? mb : ma;
        diff  = f_big - f_sml;

        // MW+1 zero guard bits keep near-cancellation exact; anything lost further down is only sticky.
        big_x  = {1'b0, m_big, {(MW+1){1'b0}}};
        sml_x  = {1'b0, m_sml, {(MW+1){1'b0}}};
        sml_sh = sml_x >> diff;
        sticky = (sml_sh << diff) != sml_x;
        if (s_big == s_sml)
            sum = big_x + sml_sh;
        else
            sum = big_x - sml_sh - EW'(sticky);

        lead = 0;
        for (int i = 0; i < EW; i++)
            if (sum[i]) lead = i;
        frac = (EW-1)'(sum << (EW - 1 - lead));
        sf_r = f_big + SW'(lead - 2 * MW);
        k_r  = sf_r >>> es;

        // Regime is produced by shifting a two-bit seed, filling with the run bit.
        if (k_r >= 0) begin
            seed    = {2'b10, sf_r[es-1:0], frac};
            shamt   = int'(k_r);
            shifted = ~((~seed) >> shamt);
        end else begin
            seed    = {2'b01, sf_r[es-1:0], frac};
            shamt   = -int'(k_r) - 1;
            shifted = seed >> shamt;
        end
        lost   = |(seed & ((TW'(1) << shamt) - TW'(1)));
        body_r = shifted[TW-1 -: N-1];
        guard  = shifted[TW-N];
        rest   = |shifted[TW-N-1:0];
        up     = guard & (rest | lost | sticky | body_r[0]);
        mag    = body_r + (N-1)'(up);
        if (k_r > SW'(N - 2))
            mag = MAXPOS;
        else if (k_r < -SW'(N - 2))
            mag = MINPOS;

        inf  = (in1 == NAR) || (in2 == NAR);
        zero = 1'b0;
        if (inf) begin
            out = NAR;
        end else if (in1 == '0) begin
            out  = in2;
            zero = (in2 == '0);
        end else if (in2 == '0) begin
            out = in1;
        end else if (sum == '0) begin
            out  = '0;
            zero = 1'b1;
        end else begin
            out = s_big ? -{1'b0, mag} : {1'b0, mag};
        end
        done = start;
    end

endmodule

// File: rtl/posit_acc.sv
// rtl/posit_acc.sv - streaming per-packet posit accumulator with sticky NaR and saturating count
module posit_acc #(
    parameter int N     = 16,
    parameter int es    = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_inf,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);
    import posit_pkg::*;

    localparam logic [N-1:0] NAR     = POSIT_NAR_MAX[POSIT_MAX_W-1 -: N];
    localparam logic [N-1:0] ZERO    = POSIT_ZERO_MAX[N-1:0];
    localparam logic [31:0]  CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t           state, state_nxt;
    logic [N-1:0]     acc, add_out;
    logic             nar, nar_new, add_inf, add_zero, xfer;
    logic [CNT_W-1:0] cnt, cnt_new;

    posit_add #(.N(N), .es(es)) u_add (
        .start (1'b1),
        .in1   (acc),
        .in2   (in_data),
        .out   (add_out),
        .inf   (add_inf),
        .zero  (add_zero),
        .done  ()
    );

    assign xfer    = in_valid & in_ready;
    assign nar_new = nar | add_inf;
    assign cnt_new = CNT_W'(sat_inc(32'(cnt), CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:  if (xfer && in_last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = (xfer && in_last) ? DONE : ACC;
            default: state_nxt = ACC;
        endcase
    end

    // in_ready depends only on state and out_ready so a source can never deadlock on it.
    always_comb begin
        out_valid = (state == DONE);
        in_ready  = (state == ACC) | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= ZERO;
            nar       <= 1'b0;
            cnt       <= '0;
            out_data  <= ZERO;
            out_inf   <= 1'b0;
            out_zero  <= 1'b0;
            out_count <= '0;
        end else if (xfer) begin
            if (in_last) begin
                out_data  <= nar_new ? NAR : add_out;
                out_inf   <= nar_new;
                out_zero  <= add_zero & ~nar_new;
                out_count <= cnt_new;
                acc       <= ZERO;
                nar       <= 1'b0;
                cnt       <= '0;
            end else begin
                acc <= add_out;
                nar <= nar_new;
                cnt <= cnt_new;
            end
        end
    end

endmodule

// File: tb/tb_posit_acc.sv
// tb/tb_posit_acc.sv - self-checking bench for posit_acc against a real-valued posit model
module tb_posit_acc;
    localparam int N     = 16;
    localparam int ES    = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_inf, out_zero;
    logic [N-1:0]     in_data, out_data;
    logic [CNT_W-1:0] out_count;
    int               checks = 0;
    int               passes = 0;

    always #5 clk = ~clk;

    posit_acc #(.N(N), .es(ES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inf   (out_inf),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    function automatic real pow2(input int s);
        real r;
        r = 1.0;
        if (s >= 0) for (int i = 0; i < s; i++) r = r * 2.0;
        else for (int i = 0; i < -s; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of a w-bit posit (NaR must be excluded by the caller).
    function automatic real pdec(input logic [31:0] bits, input int w);
        logic [31:0] mask, m, mag;
        logic        neg, rb;
        int          i, run, k, e;
        real         f, wgt;
        mask = (32'd1 << w) - 32'd1;
        m    = bits & mask;
        if (m == 0) return 0.0;
        neg = m[w-1];
        mag = neg ? ((~m + 32'd1) & mask) : m;
        i   = w - 2;
        rb  = mag[i];
        run = 0;
        while (i >= 0 && mag[i] == rb) begin run++; i--; end
        k = rb ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0 && mag[i]) ? 1 : 0);
            i--;
        end
        f   = 1.0;
        wgt = 0.5;
        while (i >= 0) begin
            if (mag[i]) f = f + wgt;
            wgt = wgt / 2.0;
            i--;
        end
        return (neg ? -f : f) * pow2(k * (1 << ES) + e);
    endfunction

    // Nearest 16-bit posit, ties decided on the encoding via the 17-bit midpoint posit.
    function automatic logic [15:0] penc(input real v);
        real         a, midv;
        int          lo, hi, md;
        logic [15:0] p;
        if (v == 0.0) return 16'h0000;
        a = (v < 0.0) ? -v : v;
        if (a <= pdec(32'h1, 16)) lo = 1;
        else if (a >= pdec(32'h7fff, 16)) lo = 32'h7fff;
        else begin
            lo = 1;
            hi = 32'h7ffe;
            while (lo < hi) begin
                md = (lo + hi + 1) / 2;
                if (pdec(32'(md), 16) <= a) lo = md;
                else hi = md - 1;
            end
            midv = pdec(32'((lo << 1) | 1), 17);
            if (a > midv || (a == midv && (lo % 2) == 1)) lo++;
        end
        p = 16'(lo);
        return (v < 0.0) ? -p : p;
    endfunction

    function automatic void model(input logic [15:0] q[$], output logic [15:0] d,
                                  output logic inf, output logic zero, output int cnt);
        logic [15:0] acc;
        logic        nar;
        acc = 16'h0;
        nar = 1'b0;
        foreach (q[i]) begin
            if (nar || q[i] == 16'h8000) nar = 1'b1;
            else acc = penc(pdec(32'(acc), 16) + pdec(32'(q[i]), 16));
        end
        cnt  = (q.size() > 255) ? 255 : q.size();
        d    = nar ? 16'h8000 : acc;
        inf  = nar;
        zero = !nar && acc == 16'h0;
    endfunction

    task automatic send_elem(input logic [15:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_data, out_inf, out_zero, out_count} !== '0)
            $display("FAIL reset_outputs got v=%b d=%h i=%b z=%b c=%0d want all 0",
                     out_valid, out_data, out_inf, out_zero, out_count);
        else passes++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passes++;
    endtask

    task automatic test_sum();
        send_elem(16'h4000, 1'b0);
        send_elem(16'h4000, 1'b1);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL sum_valid got %b want 1", out_valid); else passes++;
        checks++;
        if (out_data !== 16'h4800) $display("FAIL sum_data got %h want 4800", out_data); else passes++;
        checks++;
        if (out_count !== 8'd2 || out_inf !== 1'b0 || out_zero !== 1'b0)
            $display("FAIL sum_flags got c=%0d i=%b z=%b want 2 0 0", out_count, out_inf, out_zero);
        else passes++;
        pop();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL sum_pop got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_cancel();
        send_elem(16'h4000, 1'b0);
        send_elem(16'hC000, 1'b1);
        checks++;
        if (out_data !== 16'h0000 || out_zero !== 1'b1 || out_count !== 8'd2)
            $display("FAIL cancel got d=%h z=%b c=%0d want 0000 1 2", out_data, out_zero, out_count);
        else passes++;
        pop();
    endtask

    task automatic test_nar();
        send_elem(16'h4000, 1'b0);
        send_elem(16'h8000, 1'b0);
        send_elem(16'h4000, 1'b1);
        checks++;
        if (out_data !== 16'h8000 || out_inf !== 1'b1 || out_zero !== 1'b0 || out_count !== 8'd3)
            $display("FAIL nar got d=%h i=%b z=%b c=%0d want 8000 1 0 3",
                     out_data, out_inf, out_zero, out_count);
        else passes++;
        pop();
    endtask

    task automatic test_backpressure();
        send_elem(16'h3000, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h3000)
                $display("FAIL stall_hold cyc %0d got v=%b r=%b d=%h want 1 0 3000",
                         i, out_valid, in_ready, out_data);
            else passes++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_release got %b want 0", out_valid); else passes++;
        send_elem(16'h4000, 1'b1);
        checks++;
        if (out_data !== 16'h4800 || out_count !== 8'd2)
            $display("FAIL stall_carry got d=%h c=%0d want 4800 2", out_data, out_count);
        else passes++;
        pop();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 16'h4000;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_count !== 8'd1)
            $display("FAIL b2b_first got v=%b d=%h c=%0d want 1 4000 1", out_valid, out_data, out_count);
        else passes++;
        in_data = 16'h4800;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4800 || out_count !== 8'd1)
            $display("FAIL b2b_second got v=%b d=%h c=%0d want 1 4800 1", out_valid, out_data, out_count);
        else passes++;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passes++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send_elem(16'h4000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_data !== 16'h0 || out_count !== 8'd0 || out_valid !== 1'b0)
            $display("FAIL rstmid_async got d=%h c=%0d v=%b want 0000 0 0", out_data, out_count, out_valid);
        else passes++;
        @(posedge clk); #1 rst_n = 1'b1;
        send_elem(16'h4800, 1'b1);
        checks++;
        if (out_data !== 16'h4800 || out_count !== 8'd1)
            $display("FAIL rstmid_after got d=%h c=%0d want 4800 1", out_data, out_count);
        else passes++;
        pop();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++)
            send_elem((i % 2 == 1) ? 16'hC000 : 16'h4000, i == 299);
        checks++;
        if (out_count !== 8'd255 || out_data !== 16'h0 || out_zero !== 1'b1)
            $display("FAIL saturate got c=%0d d=%h z=%b want 255 0000 1", out_count, out_data, out_zero);
        else passes++;
        pop();
    endtask

    function automatic logic [15:0] gen_posit();
        int          r;
        logic [15:0] v;
        r = $urandom_range(0, 99);
        if (r < 4) v = 16'h8000;
        else if (r < 12) v = 16'h0000;
        else if (r < 60) begin
            v = 16'($urandom_range(16'h3000, 16'h5000));
            if ($urandom_range(0, 1) == 1) v = -v;
        end else v = 16'($urandom);
        return v;
    endfunction

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] exp_d;
        logic        exp_i, exp_z;
        int          exp_c, len;
        for (int p = 0; p < 30; p++) begin
            q.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) q.push_back(gen_posit());
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_elem(q[i], i == len - 1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            model(q, exp_d, exp_i, exp_z, exp_c);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d)
                $display("FAIL rand_data pkt %0d got v=%b d=%h want 1 %h", p, out_valid, out_data, exp_d);
            else passes++;
            checks++;
            if (out_inf !== exp_i || out_zero !== exp_z || out_count !== 8'(exp_c))
                $display("FAIL rand_flags pkt %0d got i=%b z=%b c=%0d want %b %b %0d",
                         p, out_inf, out_zero, out_count, exp_i, exp_z, exp_c);
            else passes++;
            pop();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_sum();
        test_cancel();
        test_nar();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
